path_counter: RTL and testbench

Downstream consumer of the adjacency map's query/reply interface. It counts every distinct directed path from `start_node` to `end_node` with an iterative depth-first walk. Nodes are held on an internal explicit stack. Each non-target node popped from the stack is sent as one adjacency query, and every returned neighbour is pushed back. Each time the target node is popped, the path count increments. The block assumes an acyclic graph, which holds for the puzzle input.

---
 rtl/path_counter.sv | 143 ++++++++++++++
 tb/tb_path_counter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/path_counter.sv
// Counts distinct directed paths from start_node to end_node in an acyclic graph
// by an explicit-stack depth-first walk over the adjacency map's query/reply port.
module path_counter #(
  parameter int MAX_NODES    = 1024,
  parameter int NODE_WIDTH   = $clog2(MAX_NODES),
  parameter int STACK_DEPTH  = 4096,
  parameter int RESULT_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NODE_WIDTH-1:0]   start_node,
  input  logic [NODE_WIDTH-1:0]   end_node,
  input  logic                    query_ready,
  output logic                    query_valid,
  output logic [NODE_WIDTH-1:0]   query_data,
  input  logic                    reply_valid,
  input  logic                    reply_last,
  input  logic [NODE_WIDTH-1:0]   reply_data,
  output logic                    reply_ready,
  output logic                    done,
  output logic                    overflow,
  output logic [RESULT_WIDTH-1:0] result
);

  localparam int ADDR_WIDTH = $clog2(STACK_DEPTH);
  localparam int SP_WIDTH   = ADDR_WIDTH + 1;
  localparam logic [SP_WIDTH-1:0] SP_FULL = SP_WIDTH'(STACK_DEPTH);
  localparam logic [SP_WIDTH-1:0] SP_ONE  = SP_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, POP, CHECK, QUERY, COLLECT, DONE} state_t;

  state_t                  state;
  logic [SP_WIDTH-1:0]     sp;
  logic [NODE_WIDTH-1:0]   target;
  logic [NODE_WIDTH-1:0]   cur;
  logic [NODE_WIDTH-1:0]   stack_mem [STACK_DEPTH];

  logic                    start_ok;
  logic                    beat;
  logic                    full;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [NODE_WIDTH-1:0]   wr_data;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;

  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign beat       = reply_valid && reply_ready;
  assign full       = (sp == SP_FULL);
  assign query_data = cur;
  assign rd_en      = (state == POP) && (sp != '0);
  assign rd_addr    = ADDR_WIDTH'(sp - SP_ONE);

  // The start push and a COLLECT push can never coincide, so one write port suffices.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (start_ok) begin
      wr_en   = 1'b1;
      wr_data = start_node;
    end else if (beat && !full) begin
      wr_en   = 1'b1;
      wr_addr = sp[ADDR_WIDTH-1:0];
      wr_data = reply_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) stack_mem[wr_addr] <= wr_data;
    if (rd_en) cur <= stack_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sp          <= '0;
      target      <= '0;
      query_valid <= 1'b0;
      reply_ready <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      result      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            target   <= end_node;
            sp       <= SP_ONE;
            result   <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            state    <= POP;
          end
        end
        POP: begin
          if (sp == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            sp    <= sp - SP_ONE;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (cur == target) begin
            if (result != '1) result <= result + 1'b1;
            state <= POP;
          end else begin
            query_valid <= 1'b1;
            state       <= QUERY;
          end
        end
        QUERY: begin
          if (query_ready) begin
            query_valid <= 1'b0;
            reply_ready <= 1'b1;
            state       <= COLLECT;
          end
        end
        COLLECT: begin
          if (beat) begin
            // A beat arriving on a full stack is swallowed and the run is flagged.
            if (full) overflow <= 1'b1;
            else      sp <= sp + SP_ONE;
            if (reply_last) begin
              reply_ready <= 1'b0;
              if (overflow || full) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                state <= POP;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_counter.sv
// Self-checking bench for path_counter: directed graphs, random DAGs against a
// memoised path-count model, backpressure, reset mid-reply and stack overflow.
module tb_path_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [9:0]  start_node, end_node, start_node2, end_node2;
  logic        query_ready, query_valid, query_ready2, query_valid2;
  logic [9:0]  query_data, query_data2;
  logic        reply_valid, reply_last, reply_ready;
  logic        reply_valid2, reply_last2, reply_ready2;
  logic [9:0]  reply_data, reply_data2;
  logic        done, overflow, done2, overflow2;
  logic [63:0] result, result2;

  int checks = 0;
  int fails  = 0;

  int  succ  [16][16];
  int  nsucc [16];
  int  qlog  [$];
  bit  bp_mode = 0, gap_en = 0, hang_reply = 0, abort_flag = 0;
  int  beats2 = 0, queries2 = 0;
  bit  done2_after_last = 0;

  always #5 clk = ~clk;

  path_counter dut (
    .clk(clk), .rst(rst), .start(start), .start_node(start_node), .end_node(end_node),
    .query_ready(query_ready), .query_valid(query_valid), .query_data(query_data),
    .reply_valid(reply_valid), .reply_last(reply_last), .reply_data(reply_data),
    .reply_ready(reply_ready), .done(done), .overflow(overflow), .result(result)
  );

  path_counter #(.STACK_DEPTH(4)) dut_small (
    .clk(clk), .rst(rst), .start(start2), .start_node(start_node2), .end_node(end_node2),
    .query_ready(query_ready2), .query_valid(query_valid2), .query_data(query_data2),
    .reply_valid(reply_valid2), .reply_last(reply_last2), .reply_data(reply_data2),
    .reply_ready(reply_ready2), .done(done2), .overflow(overflow2), .result(result2)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_graph();
    for (int i = 0; i < 16; i++) nsucc[i] = 0;
  endtask

  task automatic add_edge(input int a, input int b);
    succ[a][nsucc[a]] = b;
    nsucc[a]++;
  endtask

  // Paths to t summed bottom-up over the DAG; nodes are numbered so edges go upward.
  function automatic longint unsigned count_paths(input int s, input int t);
    longint unsigned cnt [16];
    for (int v = 15; v >= 0; v--) begin
      if (v == t) cnt[v] = 1;
      else begin
        cnt[v] = 0;
        for (int k = 0; k < nsucc[v]; k++) cnt[v] += cnt[succ[v][k]];
      end
    end
    return cnt[s];
  endfunction

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20000 && !done; i++) @(negedge clk);
    check_output({tag, "_done"}, done, 1);
  endtask

  task automatic apply_stimulus(input int s, input int t, input longint unsigned exp,
                                input string tag, input bit poke);
    qlog.delete();
    @(negedge clk);
    start_node = 10'(s); end_node = 10'(t); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output({tag, "_busy"}, done, 0);
    if (poke) begin
      repeat (3) @(negedge clk);
      start_node = 10'(t); end_node = 10'(t); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(tag);
    check_output({tag, "_result"}, result, exp);
    check_output({tag, "_overflow"}, overflow, 0);
  endtask

  // Adjacency map model for the main instance.
  initial begin
    query_ready = 0; reply_valid = 0; reply_last = 0; reply_data = '0;
    forever begin
      @(negedge clk);
      if (query_valid && !rst) begin : serve
        int node;
        int hold;
        node = int'(query_data);
        qlog.push_back(node);
        hold = bp_mode ? 10 : int'($urandom_range(0, 2));
        for (int c = 0; c < hold; c++) begin
          @(negedge clk);
          check_output("query_hold_valid", query_valid, 1);
          check_output("query_hold_data", query_data, 64'(node));
        end
        query_ready = 1'b1;
        @(negedge clk);
        query_ready = 1'b0;
        for (int k = 0; k < nsucc[node]; k++) begin
          if (gap_en) repeat ($urandom_range(0, 2)) @(negedge clk);
          if (hang_reply && k == 1) while (hang_reply) @(negedge clk);
          if (abort_flag) break;
          reply_valid = 1'b1;
          reply_data  = 10'(succ[node][k]);
          reply_last  = (k == nsucc[node] - 1);
          @(negedge clk);
          reply_valid = 1'b0;
          reply_last  = 1'b0;
        end
        abort_flag = 0;
      end
    end
  end

  // Small-stack instance: node 0 fans out to six non-target nodes.
  initial begin
    query_ready2 = 0; reply_valid2 = 0; reply_last2 = 0; reply_data2 = '0;
    forever begin
      @(negedge clk);
      if (query_valid2 && !rst) begin
        queries2++;
        query_ready2 = 1'b1;
        @(negedge clk);
        query_ready2 = 1'b0;
        for (int k = 0; k < 6; k++) begin
          reply_valid2 = 1'b1;
          reply_data2  = 10'(k + 1);
          reply_last2  = (k == 5);
          if (reply_ready2) beats2++;
          @(negedge clk);
          reply_valid2 = 1'b0;
          reply_last2  = 1'b0;
        end
        done2_after_last = done2;
      end
    end
  end

  initial begin
    rst = 1'b1; start = 0; start2 = 0;
    start_node = '0; end_node = '0; start_node2 = '0; end_node2 = '0;
    clear_graph();
    repeat (3) @(negedge clk);
    check_output("rst_query_valid", query_valid, 0);
    check_output("rst_reply_ready", reply_ready, 0);
    check_output("rst_done", done, 0);
    check_output("rst_overflow", overflow, 0);
    check_output("rst_result", result, 0);
    rst = 1'b0;

    apply_stimulus(5, 5, 1, "self", 0);
    check_output("self_queries", qlog.size(), 0);

    clear_graph();
    add_edge(0, 1); add_edge(1, 2);
    apply_stimulus(0, 2, 1, "chain", 0);
    check_output("chain_queries", qlog.size(), 2);
    check_output("chain_q0", qlog[0], 0);
    check_output("chain_q1", qlog[1], 1);

    clear_graph();
    add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3);
    bp_mode = 1;
    apply_stimulus(0, 3, 2, "diamond_bp", 1);
    bp_mode = 0;
    check_output("diamond_queries", qlog.size(), 3);
    check_output("diamond_q0", qlog[0], 0);

    // you=0 bbb=1 ccc=2 ddd=3 eee=4 fff=5 ggg=6 out=7
    clear_graph();
    add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(1, 4);
    add_edge(2, 3); add_edge(2, 4); add_edge(2, 5); add_edge(3, 6);
    add_edge(4, 7); add_edge(5, 7); add_edge(6, 7);
    apply_stimulus(0, 7, 5, "aoc", 0);
    apply_stimulus(0, 7, 5, "aoc_rerun", 0);
    gap_en = 1;
    apply_stimulus(0, 7, 5, "aoc_gaps", 0);
    gap_en = 0;

    clear_graph();
    add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3);
    hang_reply = 1;
    @(negedge clk);
    start_node = 10'd0; end_node = 10'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !reply_ready; i++) @(negedge clk);
    check_output("midrst_in_collect", reply_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst_query_valid", query_valid, 0);
    check_output("midrst_reply_ready", reply_ready, 0);
    check_output("midrst_done", done, 0);
    check_output("midrst_overflow", overflow, 0);
    check_output("midrst_result", result, 0);
    rst = 1'b0;
    abort_flag = 1;
    hang_reply = 0;
    repeat (3) @(negedge clk);
    apply_stimulus(0, 3, 2, "after_rst", 0);

    for (int r = 0; r < 6; r++) begin
      int s;
      clear_graph();
      for (int i = 0; i < 11; i++) begin
        for (int j = i + 1; j < 12; j++)
          if ($urandom_range(0, 2) == 0) add_edge(i, j);
        if (nsucc[i] == 0) add_edge(i, i + 1);
      end
      s = int'($urandom_range(0, 5));
      gap_en = r[0];
      apply_stimulus(s, 11, count_paths(s, 11), $sformatf("rand%0d", r), 0);
    end
    gap_en = 0;

    @(negedge clk);
    start_node2 = 10'd0; end_node2 = 10'd9; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 200 && !done2; i++) @(negedge clk);
    check_output("ovf_done", done2, 1);
    check_output("ovf_done_at_last", done2_after_last, 1);
    check_output("ovf_flag", overflow2, 1);
    check_output("ovf_beats", beats2, 6);
    check_output("ovf_queries", queries2, 1);
    check_output("ovf_result", result2, 0);
    start_node2 = 10'd9; end_node2 = 10'd9; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check_output("ovf_rerun_done_clr", done2, 0);
    check_output("ovf_rerun_ovf_clr", overflow2, 0);
    for (int i = 0; i < 200 && !done2; i++) @(negedge clk);
    check_output("ovf_rerun_done", done2, 1);
    check_output("ovf_rerun_result", result2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
